tpu_requant_pipe: RTL and testbench
===================================

Name: tpu_requant_pipe

Overview:
Multi-lane successor to the single-lane accumulator cast. Converts LANES wide signed accumulator values per beat to OUT_WIDTH signed results. Each value is arithmetically right-shifted, rounded correctly from the dropped bits, then saturated. Sits between the systolic-array accumulator drain and the output buffer, with full valid/ready backpressure and a saturation event counter readable by the CSR block.

Parameters:
LANES, 16, number of parallel channels per beat
WIDE_WIDTH, 128, signed input width per lane
OUT_WIDTH, 32, signed output width per lane (must be < WIDE_WIDTH)
SHIFT_BITS, 6, width of the shift-amount field
CNT_WIDTH, 16, width of the saturation event counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
round_mode  in  2  0=floor, 1=half-up (toward +inf), 2=half-even, 3=toward zero
shift_amount  in  SHIFT_BITS  right shift; values >= WIDE_WIDTH are clamped to WIDE_WIDTH-1
in_data  in  LANES*WIDE_WIDTH  packed signed lanes; lane i is at [i*WIDE_WIDTH +: WIDE_WIDTH]
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
out_data  out  LANES*OUT_WIDTH  packed signed results
out_sat  out  LANES  per-lane saturation flag for this beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
sat_count  out  CNT_WIDTH  beats with at least one saturated lane; sticks at all-ones
sat_clr  in  1  clears sat_count

Behaviour:
- Reset (synchronous, rst_n=0 at a clk edge): all stage valids 0, out_valid=0, out_data=0, out_sat=0, sat_count=0. in_ready is 1 in the first cycle after reset. A reset mid-operation discards every in-flight beat.
- Handshake:
  - Input transfers when in_valid&&in_ready. Output transfers when out_valid&&out_ready.
  - round_mode and shift_amount are sampled with the beat and travel with it; changing them mid-stream affects only later beats.
- Pipeline: 3 registered stages (S1 shift, S2 round, S3 saturate/output).
  - Latency from accept to out_valid is 3 cycles.
  - Throughput is 1 beat/cycle while out_ready=1.
  - Stage k advances when it is empty or stage k+1 advances. S3 advances when !out_valid || out_ready.
  - in_ready = S1 empty || S1 advances (combinational, no combinational path from in_valid).
  - No beat is dropped or duplicated under any backpressure pattern. out_data and out_sat hold stable while out_valid && !out_ready.
- S1, per lane, s = clamped shift:
  - q = in >>> s (floor).
  - half = bit s-1 of in.
  - sticky = OR of bits s-2..0.
  - If s=0: half=0 and sticky=0.
  - If s=1: sticky=0.
- S2 increment (inc):
  - mode 0: inc=0.
  - mode 1: inc=half.
  - mode 2: inc = half && (sticky || q[0]).
  - mode 3: inc = in_negative && (half || sticky).
  - r = q + inc, computed at WIDE_WIDTH+1 bits so there is no wrap.
- S3:
  - If r > 2^(OUT_WIDTH-1)-1: output = max, sat=1.
  - Else if r < -2^(OUT_WIDTH-1): output = min, sat=1.
  - Otherwise output = r[OUT_WIDTH-1:0], sat=0.
- sat_count:
  - Increments by 1 on each output transfer where |out_sat, and sticks at all-ones.
  - sat_clr takes priority: if sat_clr and an increment occur in the same cycle, the result is 0 (the event is lost).
  - Counting is at transfer, not when the beat is loaded into S3.

Test Plan:
1. Lane0 = 0x...0B (11), shift=2, all modes, out_ready=1 -> floor 2, half-up 3, half-even 3, toward-zero 2. Lane1 = -11, same modes -> -3, -3, -3, -2. Each result appears exactly 3 cycles after accept.
2. Half-even ties, shift=1 -> 5 gives 2, 7 gives 4, -5 gives -2. With shift=0 and 7 in all modes -> 7, no rounding.
3. Saturation, OUT_WIDTH=32 -> 2^31 gives 0x7FFFFFFF with sat=1. -2^31-1 gives 0x80000000 with sat=1. Max wide positive with shift=0, mode 1 gives 0x7FFFFFFF and no wrap. sat_count increments once per beat even when several lanes saturate.
4. Backpressure: stream 20 beats with a random out_ready (about 30% low) -> all 20 arrive in order with bit-exact expected values, in_ready deasserts when the pipeline is full, and out_data is stable while stalled.
5. Config change: beat A (mode 1, shift 4) is followed immediately by beat B (mode 0, shift 0) -> each result uses its own sampled configuration.
6. rst_n asserted for 1 cycle with 3 beats in flight -> no out_valid for those beats, sat_count=0. sat_clr coinciding with a saturating output transfer -> sat_count=0. Holding sat_count at all-ones plus another saturating beat -> it stays all-ones.

Source files
------------

// File: rtl/tpu_requant_pipe.sv
// Multi-lane requantiser: arithmetic right shift, rounding from the dropped bits,
// then saturation to OUT_WIDTH, in a 3-stage valid/ready pipeline with a saturation counter.
module tpu_requant_pipe #(
    parameter int LANES      = 16,
    parameter int WIDE_WIDTH = 128,
    parameter int OUT_WIDTH  = 32,
    parameter int SHIFT_BITS = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    round_mode,
    input  logic [SHIFT_BITS-1:0]         shift_amount,
    input  logic [LANES*WIDE_WIDTH-1:0]   in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [LANES*OUT_WIDTH-1:0]    out_data,
    output logic [LANES-1:0]              out_sat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_WIDTH-1:0]          sat_count,
    input  logic                          sat_clr
);

    localparam logic signed [WIDE_WIDTH:0] SAT_MAX =
        {{(WIDE_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WIDE_WIDTH:0] SAT_MIN =
        {{(WIDE_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic                  r_v1, r_v2, r_v3;
    logic [1:0]            r_mode1;
    logic [CNT_WIDTH-1:0]  r_sat_count;
    logic [SHIFT_BITS-1:0] w_shift;
    logic                  w_adv1, w_adv2, w_adv3;

    // A stage may load when it is empty or its contents move on this edge.
    assign w_adv3    = !r_v3 || out_ready;
    assign w_adv2    = !r_v2 || w_adv3;
    assign w_adv1    = !r_v1 || w_adv2;
    assign in_ready  = w_adv1;
    assign out_valid = r_v3;
    assign sat_count = r_sat_count;

    always_comb begin
        w_shift = shift_amount;
        if (int'(shift_amount) >= WIDE_WIDTH) begin
            w_shift = SHIFT_BITS'(WIDE_WIDTH - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_adv1) r_v1 <= in_valid;
            if (w_adv2) r_v2 <= r_v1;
            if (w_adv3) r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv1) r_mode1 <= round_mode;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (out_valid && out_ready && (|out_sat) && !(&r_sat_count)) begin
            r_sat_count <= r_sat_count + CNT_WIDTH'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [WIDE_WIDTH-1:0] w_in;
            logic [WIDE_WIDTH-1:0]        w_half_bit, w_sticky_mask;
            logic                         w_half, w_sticky, w_inc;
            logic signed [WIDE_WIDTH:0]   w_r;
            logic [OUT_WIDTH-1:0]         w_o;
            logic                         w_s;
            logic signed [WIDE_WIDTH-1:0] r_q;
            logic                         r_half, r_sticky, r_neg;
            logic signed [WIDE_WIDTH:0]   r_r;
            logic [OUT_WIDTH-1:0]         r_o;
            logic                         r_s;

            assign w_in          = in_data[gi*WIDE_WIDTH +: WIDE_WIDTH];
            // Bit s-1 is the half position; everything below it feeds sticky.
            assign w_half_bit    = WIDE_WIDTH'(1) << (w_shift - SHIFT_BITS'(1));
            assign w_sticky_mask = w_half_bit - WIDE_WIDTH'(1);
            assign w_half        = (w_shift != '0) && (|(w_in & w_half_bit));
            assign w_sticky      = (w_shift > SHIFT_BITS'(1)) && (|(w_in & w_sticky_mask));

            always_ff @(posedge clk) begin
                if (w_adv1) begin
                    r_q      <= w_in >>> w_shift;
                    r_half   <= w_half;
                    r_sticky <= w_sticky;
                    r_neg    <= w_in[WIDE_WIDTH-1];
                end
            end

            always_comb begin
                w_inc = 1'b0;
                case (r_mode1)
                    2'd1:    w_inc = r_half;
                    2'd2:    w_inc = r_half && (r_sticky || r_q[0]);
                    2'd3:    w_inc = r_neg && (r_half || r_sticky);
                    default: w_inc = 1'b0;
                endcase
            end

            assign w_r = {r_q[WIDE_WIDTH-1], r_q} + {{WIDE_WIDTH{1'b0}}, w_inc};

            always_ff @(posedge clk) begin
                if (w_adv2) r_r <= w_r;
            end

            always_comb begin
                w_o = r_r[OUT_WIDTH-1:0];
                w_s = 1'b0;
                if (r_r > SAT_MAX) begin
                    w_o = OUT_MAX;
                    w_s = 1'b1;
                end else if (r_r < SAT_MIN) begin
                    w_o = OUT_MIN;
                    w_s = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_o <= '0;
                    r_s <= 1'b0;
                end else if (w_adv3) begin
                    r_o <= w_o;
                    r_s <= w_s;
                end
            end

            assign out_data[gi*OUT_WIDTH +: OUT_WIDTH] = r_o;
            assign out_sat[gi]                         = r_s;
        end
    endgenerate

endmodule

// File: tb/tb_tpu_requant_pipe.sv
// Bench for tpu_requant_pipe: directed and random beats scored against a
// division/remainder model of shift-round-saturate plus a saturation-count model.
module tb_tpu_requant_pipe;
    localparam int L  = 16;
    localparam int W  = 128;
    localparam int O  = 32;
    localparam int SB = 6;
    localparam int CW = 4;

    typedef struct {
        logic [L*O-1:0] d;
        logic [L-1:0]   s;
        int             cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       round_mode;
    logic [SB-1:0]    shift_amount;
    logic [L*W-1:0]   in_data;
    logic             in_valid;
    logic             in_ready;
    logic [L*O-1:0]   out_data;
    logic [L-1:0]     out_sat;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    sat_count;
    logic             sat_clr;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int beats_out = 0;
    bit lat_check = 0;
    bit or_rand = 0;
    exp_t exp_q[$];
    int exp_cnt = 0;
    bit stalled = 0;
    logic [L*O-1:0] hold_d;
    logic [L-1:0]   hold_s;

    tpu_requant_pipe #(.LANES(L), .WIDE_WIDTH(W), .OUT_WIDTH(O), .SHIFT_BITS(SB), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .round_mode(round_mode), .shift_amount(shift_amount),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
        .sat_count(sat_count), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [L*O-1:0] act, input logic [L*O-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Result = floor(x / 2^s) plus a rounding step decided from the remainder.
    function automatic logic [O:0] model_lane(input logic signed [W-1:0] x, input int s, input int m);
        logic signed [W+1:0] xv, q, rem, unit, r, maxv, minv;
        int inc;
        xv   = x;
        q    = xv >>> s;
        rem  = xv - (q <<< s);
        unit = 1;
        unit = unit <<< s;
        case (m)
            1:       inc = (rem * 2 >= unit) ? 1 : 0;
            2:       inc = ((rem * 2 > unit) || (rem * 2 == unit && q[0])) ? 1 : 0;
            3:       inc = (xv < 0 && rem != 0) ? 1 : 0;
            default: inc = 0;
        endcase
        r    = q + inc;
        maxv = 1;
        maxv = (maxv <<< (O - 1)) - 1;
        minv = -maxv - 1;
        if (r > maxv)      return {1'b1, 1'b0, {(O-1){1'b1}}};
        else if (r < minv) return {1'b1, 1'b1, {(O-1){1'b0}}};
        else               return {1'b0, r[O-1:0]};
    endfunction

    function automatic exp_t model_beat(input logic [L*W-1:0] d, input logic [1:0] m, input logic [SB-1:0] sh);
        exp_t e;
        logic [O:0] res;
        int s;
        s = (int'(sh) >= W) ? W - 1 : int'(sh);
        for (int i = 0; i < L; i++) begin
            res = model_lane(d[i*W +: W], s, int'(m));
            e.d[i*O +: O] = res[O-1:0];
            e.s[i] = res[O];
        end
        e.cyc = cyc;
        return e;
    endfunction

    function automatic logic signed [W-1:0] rnd_lane();
        logic signed [W-1:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom()};
        v = v >>> $urandom_range(0, W - 1);
        return v;
    endfunction

    // Scoreboard / compare process, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        bit xfer_sat;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt = 0;
            stalled = 0;
        end else begin
            xfer_sat = 0;
            chk("sat_count", L*O'(sat_count), L*O'(exp_cnt));
            chk("in_ready", L*O'(in_ready), L*O'(!(exp_q.size() == 3 && !out_ready)));
            if (stalled && out_valid) begin
                chk("stall_hold_data", out_data, hold_d);
                chk("stall_hold_sat", L*O'(out_sat), L*O'(hold_s));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", L*O'(1), L*O'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_sat", L*O'(out_sat), L*O'(e.s));
                    if (lat_check) chk("latency", L*O'(cyc - e.cyc), L*O'(3));
                    xfer_sat = |e.s;
                    beats_out++;
                    $display("[TB] out beat %0d lane0=%h lane1=%h sat=%h", beats_out,
                             out_data[O-1:0], out_data[2*O-1:O], out_sat);
                end
            end
            if (sat_clr) exp_cnt = 0;
            else if (xfer_sat && exp_cnt != (1 << CW) - 1) exp_cnt++;
            stalled = out_valid && !out_ready;
            hold_d  = out_data;
            hold_s  = out_sat;
            if (in_valid && in_ready) exp_q.push_back(model_beat(in_data, round_mode, shift_amount));
        end
    end

    always @(posedge clk) begin
        #1;
        if (or_rand) out_ready = ($urandom_range(0, 99) >= 30);
    end

    task automatic send(input logic [L*W-1:0] d, input logic [1:0] m, input logic [SB-1:0] sh);
        bit acc;
        int n;
        in_data = d; round_mode = m; shift_amount = sh; in_valid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", L*O'(0), L*O'(1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", L*O'(exp_q.size()), L*O'(0));
        @(posedge clk); #1;
    endtask

    function automatic logic [L*W-1:0] lanes3(input logic signed [W-1:0] a, b, c);
        logic [L*W-1:0] d;
        d = '0;
        d[0 +: W] = a; d[W +: W] = b; d[2*W +: W] = c;
        return d;
    endfunction

    initial begin
        logic signed [W-1:0] big;
        logic [L*W-1:0] d;
        logic [L*W-1:0] sat_beat;
        rst_n = 0; in_valid = 0; in_data = '0; round_mode = 0; shift_amount = 0;
        out_ready = 1; sat_clr = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_out_valid", L*O'(out_valid), L*O'(0));
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sat", L*O'(out_sat), L*O'(0));
        chk("rst_sat_count", L*O'(sat_count), L*O'(0));
        chk("rst_in_ready", L*O'(in_ready), L*O'(1));

        // Literal expectations that pin the model.
        chk("pin_11_floor", L*O'(model_lane(11, 2, 0)), L*O'(33'h0_00000002));
        chk("pin_11_halfup", L*O'(model_lane(11, 2, 1)), L*O'(33'h0_00000003));
        chk("pin_11_even", L*O'(model_lane(11, 2, 2)), L*O'(33'h0_00000003));
        chk("pin_11_tz", L*O'(model_lane(11, 2, 3)), L*O'(33'h0_00000002));
        chk("pin_m11_halfup", L*O'(model_lane(-11, 2, 1)), L*O'(33'h0_FFFFFFFD));
        chk("pin_m11_tz", L*O'(model_lane(-11, 2, 3)), L*O'(33'h0_FFFFFFFE));
        chk("pin_7_even", L*O'(model_lane(7, 1, 2)), L*O'(33'h0_00000004));
        chk("pin_m5_even", L*O'(model_lane(-5, 1, 2)), L*O'(33'h0_FFFFFFFE));
        chk("pin_24_halfup", L*O'(model_lane(24, 4, 1)), L*O'(33'h0_00000002));
        big = 128'sh1 <<< 31;
        chk("pin_sat_max", L*O'(model_lane(big, 0, 0)), L*O'(33'h1_7FFFFFFF));
        chk("pin_sat_min", L*O'(model_lane(-big - 1, 0, 0)), L*O'(33'h1_80000000));

        // Rounding modes with 11 / -11, checking the 3-cycle latency.
        lat_check = 1;
        for (int m = 0; m < 4; m++) send(lanes3(11, -11, 0), 2'(m), 6'd2);
        drain();
        // Half-even ties and shift of zero.
        send(lanes3(5, 7, -5), 2'd2, 6'd1);
        for (int m = 0; m < 4; m++) send(lanes3(7, -7, 0), 2'(m), 6'd0);
        drain();
        // Saturation: several lanes saturate in one beat.
        big = 128'sh1 <<< 31;
        sat_beat = lanes3(big, -big - 1, {1'b0, {(W-1){1'b1}}});
        send(sat_beat, 2'd1, 6'd0);
        drain();
        lat_check = 0;

        // Random stream under backpressure.
        or_rand = 1;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < L; i++) d[i*W +: W] = rnd_lane();
            send(d, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
        end
        or_rand = 0;
        #1 out_ready = 1;
        drain();

        // Configuration travels with each beat.
        send(lanes3(24, -24, rnd_lane()), 2'd1, 6'd4);
        send(lanes3(24, -24, rnd_lane()), 2'd0, 6'd0);
        drain();

        // Reset with three beats in flight.
        out_ready = 0;
        for (int b = 0; b < 3; b++) send(sat_beat, 2'd0, 6'd0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; out_ready = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_no_valid", L*O'(out_valid), L*O'(0));
        end
        chk("post_rst_sat_count", L*O'(sat_count), L*O'(0));
        @(posedge clk); #1;

        // sat_clr coinciding with a saturating transfer wins.
        send(sat_beat, 2'd0, 6'd0);
        drain();
        send(sat_beat, 2'd0, 6'd0);
        repeat (2) @(posedge clk);
        #1 sat_clr = 1;
        @(posedge clk);
        #1 sat_clr = 0;
        @(negedge clk);
        chk("clr_priority", L*O'(sat_count), L*O'(0));
        drain();

        // Counter sticks at all-ones.
        for (int b = 0; b < (1 << CW) + 2; b++) send(sat_beat, 2'd0, 6'd0);
        drain();
        @(negedge clk);
        chk("sat_count_sticky", L*O'(sat_count), L*O'((1 << CW) - 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
